// File: rtl/fp_subtractor_seq.sv
// ============================================================================
// Module      : fp_subtractor_seq
// Description : Multi-cycle IEEE-754 single-precision subtractor
//               (operand1 - operand2). Aligns by shifting the smaller
//               operand one bit per cycle and normalises one bit per cycle.
//               Discarded bits are truncated. Exponent-0 inputs are flushed
//               to zero, and no denormal result is ever produced.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_subtractor_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX    = 8'hFF;
    localparam logic [7:0]  ALIGN_FLUSH = 8'd25;

    state_t      state, state_next;
    logic        a_sign, a_sign_next;
    logic        b_sign, b_sign_next;
    logic [24:0] mant_a, mant_a_next;
    logic [24:0] mant_b, mant_b_next;
    logic [7:0]  exponent, exponent_next;
    logic [7:0]  diff, diff_next;
    logic        shift_b, shift_b_next;
    logic        res_sign, res_sign_next;
    logic [31:0] result_next;

    logic [7:0]  exp1, exp2;

    assign exp1 = operand1[30:23];
    assign exp2 = operand2[30:23];

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // State and datapath registers; reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sign   <= 1'b0;
            b_sign   <= 1'b0;
            mant_a   <= '0;
            mant_b   <= '0;
            exponent <= '0;
            diff     <= '0;
            shift_b  <= 1'b0;
            res_sign <= 1'b0;
            result   <= '0;
        end else begin
            state    <= state_next;
            a_sign   <= a_sign_next;
            b_sign   <= b_sign_next;
            mant_a   <= mant_a_next;
            mant_b   <= mant_b_next;
            exponent <= exponent_next;
            diff     <= diff_next;
            shift_b  <= shift_b_next;
            res_sign <= res_sign_next;
            result   <= result_next;
        end
    end

    // Next-state and datapath update; mant_a doubles as the working mantissa
    // after the ADD step, sign of the subtrahend is inverted on capture
    always_comb begin
        state_next    = state;
        a_sign_next   = a_sign;
        b_sign_next   = b_sign;
        mant_a_next   = mant_a;
        mant_b_next   = mant_b;
        exponent_next = exponent;
        diff_next     = diff;
        shift_b_next  = shift_b;
        res_sign_next = res_sign;
        result_next   = result;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_sign_next = operand1[31];
                    b_sign_next = ~operand2[31];
                    mant_a_next = {2'b01, operand1[22:0]};
                    mant_b_next = {2'b01, operand2[22:0]};
                    if (exp1 == EXP_MAX || exp2 == EXP_MAX) begin
                        result_next = QNAN;
                        state_next  = DONE;
                    end else if (exp1 == 8'd0 && exp2 == 8'd0) begin
                        result_next = 32'h0000_0000;
                        state_next  = DONE;
                    end else if (exp2 == 8'd0) begin
                        result_next = operand1;
                        state_next  = DONE;
                    end else if (exp1 == 8'd0) begin
                        result_next = {~operand2[31], operand2[30:0]};
                        state_next  = DONE;
                    end else if (exp1 >= exp2) begin
                        exponent_next = exp1;
                        diff_next     = exp1 - exp2;
                        shift_b_next  = 1'b1;
                        state_next    = ALIGN;
                    end else begin
                        exponent_next = exp2;
                        diff_next     = exp2 - exp1;
                        shift_b_next  = 1'b0;
                        state_next    = ALIGN;
                    end
                end
            end

            ALIGN: begin
                if (diff == 8'd0) begin
                    state_next = ADD;
                end else if (diff >= ALIGN_FLUSH) begin
                    // Everything would shift out: skip the per-bit walk
                    if (shift_b) mant_b_next = '0;
                    else         mant_a_next = '0;
                    diff_next  = 8'd0;
                    state_next = ADD;
                end else begin
                    if (shift_b) mant_b_next = mant_b >> 1;
                    else         mant_a_next = mant_a >> 1;
                    diff_next = diff - 8'd1;
                end
            end

            ADD: begin
                if (a_sign == b_sign) begin
                    mant_a_next   = mant_a + mant_b;
                    res_sign_next = a_sign;
                    state_next    = NORM;
                end else if (mant_a > mant_b) begin
                    mant_a_next   = mant_a - mant_b;
                    res_sign_next = a_sign;
                    state_next    = NORM;
                end else if (mant_b > mant_a) begin
                    mant_a_next   = mant_b - mant_a;
                    res_sign_next = b_sign;
                    state_next    = NORM;
                end else begin
                    result_next = 32'h0000_0000;
                    state_next  = DONE;
                end
            end

            NORM: begin
                if (mant_a[24]) begin
                    mant_a_next   = mant_a >> 1;
                    exponent_next = exponent + 8'd1;
                    if (exponent == (EXP_MAX - 8'd1)) begin
                        result_next = {res_sign, EXP_MAX, 23'd0};
                        state_next  = DONE;
                    end
                end else if (mant_a[23]) begin
                    result_next = {res_sign, exponent, mant_a[22:0]};
                    state_next  = DONE;
                end else if (exponent == 8'd1) begin
                    // Would become denormal: flush to signed zero
                    result_next = {res_sign, 31'd0};
                    state_next  = DONE;
                end else begin
                    mant_a_next   = mant_a << 1;
                    exponent_next = exponent - 8'd1;
                end
            end

            DONE: begin
                if (out_ready) state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

`default_nettype wire
